// File: rtl/sim_exit_pkg.sv
// rtl/sim_exit_pkg.sv - shared types and constants for the end-of-test monitor
package sim_exit_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } exit_state_e;

    localparam logic [31:0] DEFAULT_TOHOST_PC   = 32'h8000_0086;
    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h8000_1000;
    localparam logic [31:0] PASS_X3             = 32'd1;

    function automatic logic is_pass_code(input logic [31:0] v);
        return v == PASS_X3;
    endfunction

endpackage

// File: rtl/sim_exit_satcnt.sv
// rtl/sim_exit_satcnt.sv - saturating up-counter with clear and freeze
module sim_exit_satcnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic         freeze,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !freeze && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/sim_exit_monitor.sv
// rtl/sim_exit_monitor.sv - end-of-test monitor: tohost PC hits, settle, x3 verdict, timeout
// Optional tohost store termination when SIM_EXIT_TOHOST_STORE_EN is defined.
module sim_exit_monitor
    import sim_exit_pkg::*;
#(
    parameter logic [31:0] TOHOST_PC   = DEFAULT_TOHOST_PC,
    parameter int          HIT_TARGET  = 8,
    parameter int          SETTLE_CYC  = 4,
    parameter logic [31:0] TIMEOUT_CYC = 32'd50000,
    parameter int          CNT_W       = 32
`ifdef SIM_EXIT_TOHOST_STORE_EN
    ,
    parameter logic [31:0] TOHOST_ADDR = DEFAULT_TOHOST_ADDR
`endif
) (
    input  logic             clk,
    input  logic             cpurst,
    input  logic             inst_valid,
    input  logic [31:0]      inst_pc,
    input  logic [31:0]      x3_val,
`ifdef SIM_EXIT_TOHOST_STORE_EN
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
`endif
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count,
    output logic [7:0]       hit_count,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [31:0]      result_x3
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 32'd1);
    localparam logic [3:0]       SETTLE_INIT  = 4'(SETTLE_CYC);
    localparam logic [8:0]       HIT_FINAL    = 9'(HIT_TARGET);

    exit_state_e state, state_next;
    logic [3:0]  settle_cnt, settle_next;
    logic        hit, final_hit, timeout_hit;
    logic        store_hit;
    logic [31:0] store_data;
    logic        enter_done;
    logic        v_pass, v_timeout;
    logic [31:0] v_x3;

    assign hit         = inst_valid && (inst_pc == TOHOST_PC);
    assign final_hit   = hit && (({1'b0, hit_count} + 9'd1) == HIT_FINAL);
    assign timeout_hit = (cycle_count == TIMEOUT_LAST);

`ifdef SIM_EXIT_TOHOST_STORE_EN
    assign store_hit  = st_valid && (st_addr == TOHOST_ADDR) && (st_data != 32'd0);
    assign store_data = st_data;
`else
    assign store_hit  = 1'b0;
    assign store_data = 32'd0;
`endif

    // Priority in RUN: tohost store, then final PC hit, then timeout.
    always_comb begin
        state_next  = state;
        settle_next = settle_cnt;
        enter_done  = 1'b0;
        v_pass      = 1'b0;
        v_timeout   = 1'b0;
        v_x3        = x3_val;
        case (state)
            RUN: begin
                if (store_hit) begin
                    state_next = DONE;
                    enter_done = 1'b1;
                    v_pass     = is_pass_code(store_data);
                    v_x3       = store_data >> 1;
                end else if (final_hit) begin
                    if (SETTLE_CYC == 0) begin
                        state_next = DONE;
                        enter_done = 1'b1;
                        v_pass     = is_pass_code(x3_val);
                    end else begin
                        state_next  = SETTLE;
                        settle_next = SETTLE_INIT;
                    end
                end else if (timeout_hit) begin
                    state_next = DONE;
                    enter_done = 1'b1;
                    v_timeout  = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_next = DONE;
                    enter_done = 1'b1;
                    v_pass     = is_pass_code(x3_val);
                end else begin
                    settle_next = settle_cnt - 4'd1;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            state      <= RUN;
            settle_cnt <= 4'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            result_x3  <= 32'd0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_next;
            if (enter_done) begin
                done      <= 1'b1;
                pass      <= v_pass;
                timeout   <= v_timeout;
                result_x3 <= v_x3;
            end
        end
    end

    // The cycle counter stops on the DONE entry edge so a timeout reads TIMEOUT_CYC-1;
    // retire and hit counters still take the instruction seen on that edge.
    sim_exit_satcnt #(.W(CNT_W)) u_cycle_cnt (
        .clk    (clk),
        .rst    (cpurst),
        .inc    (1'b1),
        .clr    (1'b0),
        .freeze (state_next == DONE),
        .count  (cycle_count)
    );

    sim_exit_satcnt #(.W(CNT_W)) u_instret_cnt (
        .clk    (clk),
        .rst    (cpurst),
        .inc    (inst_valid),
        .clr    (1'b0),
        .freeze (state == DONE),
        .count  (instret_count)
    );

    sim_exit_satcnt #(.W(8)) u_hit_cnt (
        .clk    (clk),
        .rst    (cpurst),
        .inc    (hit),
        .clr    (1'b0),
        .freeze (state == DONE),
        .count  (hit_count)
    );

endmodule

// File: tb/tb_sim_exit_monitor.sv
// tb/tb_sim_exit_monitor.sv - directed scoreboard bench for sim_exit_monitor
module tb_sim_exit_monitor;

    localparam logic [31:0] TOHOST_PC   = 32'h8000_0086;
    localparam logic [31:0] TOHOST_ADDR = 32'h8000_1000;
    localparam int          TMO         = 100;

    logic        clk;
    logic        cpurst;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] x3_val;
`ifdef SIM_EXIT_TOHOST_STORE_EN
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
`endif
    logic [31:0] cycle_count;
    logic [31:0] instret_count;
    logic [7:0]  hit_count;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [31:0] result_x3;

    sim_exit_monitor #(
        .TOHOST_PC   (TOHOST_PC),
        .HIT_TARGET  (8),
        .SETTLE_CYC  (4),
        .TIMEOUT_CYC (32'd100),
        .CNT_W       (32)
`ifdef SIM_EXIT_TOHOST_STORE_EN
        ,
        .TOHOST_ADDR (TOHOST_ADDR)
`endif
    ) dut (
        .clk           (clk),
        .cpurst        (cpurst),
        .inst_valid    (inst_valid),
        .inst_pc       (inst_pc),
        .x3_val        (x3_val),
`ifdef SIM_EXIT_TOHOST_STORE_EN
        .st_valid      (st_valid),
        .st_addr       (st_addr),
        .st_data       (st_data),
`endif
        .cycle_count   (cycle_count),
        .instret_count (instret_count),
        .hit_count     (hit_count),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .result_x3     (result_x3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          done_edge;
        logic        pass;
        logic        timeout;
        logic [31:0] x3;
        logic [31:0] hits;
        logic [31:0] instret;
        logic [31:0] cycles;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // current case stimulus description
    int          hs, hp, hn, stc;
    logic [31:0] stv;
    bit          noise;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_hit(int c);
        return (hn > 0) && (c >= hs) && ((c - hs) % hp == 0) && ((c - hs) / hp < hn);
    endfunction

    function automatic bit is_valid(int c);
        return is_hit(c) || (noise && (c % 2 == 0));
    endfunction

    task automatic predict(input logic [31:0] x3);
        exp_t e;
        int   f = -1;
        int   last;
        if (hn >= 8) f = hs + 7 * hp;
        if (stc >= 0 && (f < 0 || stc <= f) && stc <= TMO - 1) begin
            last = stc;
            e.done_edge = stc + 1;
            e.pass = (stv == 32'd1);
            e.timeout = 1'b0;
            e.x3 = stv >> 1;
        end else if (f >= 0 && f <= TMO - 1) begin
            last = f + 5;
            e.done_edge = f + 6;
            e.pass = (x3 == 32'd1);
            e.timeout = 1'b0;
            e.x3 = x3;
        end else begin
            last = TMO - 1;
            e.done_edge = TMO;
            e.pass = 1'b0;
            e.timeout = 1'b1;
            e.x3 = x3;
        end
        e.cycles = 32'(last);
        e.hits = 0;
        e.instret = 0;
        for (int c = 0; c <= last; c++) begin
            if (is_hit(c)) e.hits++;
            if (is_valid(c)) e.instret++;
        end
        sb.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ":done0"}, 32'(done), 32'd0);
        chk({tag, ":pass0"}, 32'(pass), 32'd0);
        chk({tag, ":tmo0"}, 32'(timeout), 32'd0);
        chk({tag, ":x3_0"}, result_x3, 32'd0);
        chk({tag, ":cyc0"}, cycle_count, 32'd0);
        chk({tag, ":ret0"}, instret_count, 32'd0);
        chk({tag, ":hit0"}, 32'(hit_count), 32'd0);
    endtask

    task automatic chk_verdict(input string tag, input exp_t e);
        chk({tag, ":done"}, 32'(done), 32'd1);
        chk({tag, ":pass"}, 32'(pass), 32'(e.pass));
        chk({tag, ":tmo"}, 32'(timeout), 32'(e.timeout));
        chk({tag, ":x3"}, result_x3, e.x3);
        chk({tag, ":hits"}, 32'(hit_count), e.hits);
        chk({tag, ":instret"}, instret_count, e.instret);
        chk({tag, ":cycles"}, cycle_count, e.cycles);
    endtask

    task automatic drive(input int c);
        inst_valid = is_valid(c);
        inst_pc    = is_hit(c) ? TOHOST_PC : (32'h8000_0100 + 32'(c * 4));
`ifdef SIM_EXIT_TOHOST_STORE_EN
        st_valid = (c == stc);
        st_addr  = TOHOST_ADDR;
        st_data  = (c == stc) ? stv : 32'h0000_0003;
`endif
    endtask

    task automatic run_case(input string tag, input int h_start, input int h_per, input int h_num,
                            input logic [31:0] x3, input bit nz, input int s_cyc,
                            input logic [31:0] s_val, input int abort_edge);
        exp_t e;
        bit   seen = 0;
        int   c;
        hs = h_start; hp = h_per; hn = h_num; noise = nz; stc = s_cyc; stv = s_val;
        cpurst = 1'b1;
        inst_valid = 1'b0;
        inst_pc = 32'd0;
        x3_val = x3;
`ifdef SIM_EXIT_TOHOST_STORE_EN
        st_valid = 1'b0;
        st_addr = 32'd0;
        st_data = 32'd0;
`endif
        step();
        step();
        chk_zero({tag, ":reset"});
        if (abort_edge == 0) predict(x3);
        cpurst = 1'b0;
        for (c = 0; c < 200 && !seen; c++) begin
            drive(c);
            step();
            if (abort_edge == c + 1) begin
                cpurst = 1'b1;
                #1;
                chk_zero({tag, ":abort"});
                return;
            end
            if (done) begin
                seen = 1;
                e = sb.pop_front();
                chk({tag, ":edge"}, 32'(c + 1), 32'(e.done_edge));
                chk_verdict(tag, e);
            end
        end
        if (!seen) begin
            chk({tag, ":done_seen"}, 32'(done), 32'd1);
            void'(sb.pop_front());
            return;
        end
        x3_val = ~x3;
        for (int k = 0; k < 6; k++) begin
            drive(c + k);
            step();
        end
        chk_verdict({tag, ":frozen"}, e);
    endtask

    initial begin
        run_case("pass",       2, 3, 8,  32'd1,      1'b1, -1, 32'd0, 0);
        run_case("fail_x3",    2, 3, 8,  32'd5,      1'b1, -1, 32'd0, 0);
        run_case("timeout",    0, 1, 0,  32'h1234,   1'b1, -1, 32'd0, 0);
        run_case("tmo_7hits", 10, 5, 7,  32'd1,      1'b0, -1, 32'd0, 0);
        run_case("hit_at_tmo",78, 3, 12, 32'd1,      1'b1, -1, 32'd0, 0);
        run_case("abort",      2, 3, 8,  32'd1,      1'b1, -1, 32'd0, 26);
        run_case("rerun",      2, 3, 8,  32'd1,      1'b1, -1, 32'd0, 0);
`ifdef SIM_EXIT_TOHOST_STORE_EN
        run_case("store_fail", 2, 3, 8,  32'd1,      1'b1, 10, 32'd7, 0);
        run_case("store_pass", 2, 3, 8,  32'd5,      1'b1, 10, 32'd1, 0);
        run_case("store_tie",  2, 3, 8,  32'd5,      1'b1, 23, 32'd1, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
